// File: rtl/usb_eop_fsm.sv
// USB receive-path line-state tracker: samples D+/D- on each bit strobe, measures
// SE0 run length and reports valid EOPs, malformed SE0 terminations and bus reset.
module usb_eop_fsm #(
    parameter int SE0_MIN_BITS = 2,
    parameter int SE0_MAX_BITS = 3,
    parameter int RESET_BITS   = 10,
    parameter bit LOW_SPEED    = 1'b0,
    localparam int CNT_W       = $clog2(RESET_BITS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic shift_enable,
    output logic eop,
    output logic line_error,
    output logic se0_active,
    output logic bus_reset
);

    typedef enum logic [1:0] {
        LINE       = 2'd0,
        SE0_RUN    = 2'd1,
        RESET_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_SE1 = 2'b11;
    localparam logic [1:0] SYM_J   = LOW_SPEED ? 2'b01 : 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(SE0_MIN_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SE0_MAX_BITS);
    localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(RESET_BITS);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             eop_r, eop_s;
    logic             line_error_r, line_error_s;
    logic             se0_active_r, se0_active_s;
    logic             bus_reset_r, bus_reset_s;

    logic [1:0] sym_s;
    logic       is_se0_s, is_se1_s, is_j_s;

    assign sym_s    = {d_plus, d_minus};
    assign is_se0_s = (sym_s == SYM_SE0);
    assign is_se1_s = (sym_s == SYM_SE1);
    assign is_j_s   = (sym_s == SYM_J);

    // Next-state and next-output decode; only evaluated on a bit strobe.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        eop_s        = 1'b0;
        line_error_s = 1'b0;
        se0_active_s = se0_active_r;
        bus_reset_s  = bus_reset_r;
        if (shift_enable) begin
            se0_active_s = is_se0_s;
            case (state_r)
                LINE: begin
                    if (is_se0_s) begin
                        cnt_s   = CNT_ONE;
                        state_s = SE0_RUN;
                    end else if (is_se1_s) begin
                        line_error_s = 1'b1;
                    end else begin
                        state_s = LINE;
                    end
                end
                SE0_RUN: begin
                    if (is_se0_s) begin
                        cnt_s = cnt_r + CNT_ONE;
                        if ((cnt_r + CNT_ONE) == CNT_RESET) begin
                            bus_reset_s = 1'b1;
                            state_s     = RESET_HOLD;
                        end else begin
                            state_s = SE0_RUN;
                        end
                    end else begin
                        // J ends a run cleanly only when its length is in range.
                        if (is_j_s && (cnt_r >= CNT_MIN) && (cnt_r <= CNT_MAX)) begin
                            eop_s = 1'b1;
                        end else begin
                            line_error_s = 1'b1;
                        end
                        cnt_s   = CNT_ZERO;
                        state_s = LINE;
                    end
                end
                RESET_HOLD: begin
                    if (is_se0_s) begin
                        cnt_s       = CNT_RESET;
                        bus_reset_s = 1'b1;
                    end else begin
                        cnt_s       = CNT_ZERO;
                        bus_reset_s = 1'b0;
                        state_s     = LINE;
                    end
                end
                default: begin
                    cnt_s       = CNT_ZERO;
                    bus_reset_s = 1'b0;
                    state_s     = LINE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, run counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= LINE;
            cnt_r        <= CNT_ZERO;
            eop_r        <= 1'b0;
            line_error_r <= 1'b0;
            se0_active_r <= 1'b0;
            bus_reset_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            eop_r        <= eop_s;
            line_error_r <= line_error_s;
            se0_active_r <= se0_active_s;
            bus_reset_r  <= bus_reset_s;
        end
    end

    assign eop        = eop_r;
    assign line_error = line_error_r;
    assign se0_active = se0_active_r;
    assign bus_reset  = bus_reset_r;

endmodule

// File: doc/usb_eop_fsm.md
# usb_eop_fsm

Sequential, parametrised end-of-packet and line-state detector for the USB receive path. It samples the differential pair once per bit strobe and tracks how long SE0 has been held. It reports a valid EOP, a malformed SE0, or a bus reset. It sits between the input synchronizers / bit-strobe generator and the receive controller, replacing purely combinational SE0 decoding.

## Interface
- SE0_MIN_BITS, 2, minimum SE0 bit-times for a valid EOP
- SE0_MAX_BITS, 3, maximum SE0 bit-times for a valid EOP
- RESET_BITS, 10, SE0 bit-times that constitute a bus reset
- LOW_SPEED, 0, 0: J = (d_plus=1, d_minus=0); 1: J and K swapped
- Constraint: 1 ≤ SE0_MIN_BITS ≤ SE0_MAX_BITS < RESET_BITS
- Counter width: CNT_W = $clog2(RESET_BITS+1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- d_plus  in  1  synchronized D+
- d_minus  in  1  synchronized D-
- shift_enable  in  1  one-clk bit strobe; the line is sampled only when high
- eop  out  1  one-clk pulse: valid EOP (SE0 run within [MIN, MAX] followed by J)
- line_error  out  1  one-clk pulse: malformed SE0 termination or SE1 sampled
- se0_active  out  1  level: last sampled symbol was SE0
- bus_reset  out  1  level: SE0 held ≥ RESET_BITS strobes, until the line leaves SE0

## Operation
- Symbol decode on each strobe:
  - SE0 = 00
  - SE1 = 11
  - J = 10 (01 if LOW_SPEED)
  - K = the complement of J
- States: LINE, SE0_RUN, RESET_HOLD; a CNT_W-bit counter holds the SE0 run length.
- LINE:
  - SE0 → cnt=1, go to SE0_RUN.
  - SE1 → pulse line_error, stay.
  - J or K → stay.
- SE0_RUN:
  - SE0 → cnt=cnt+1. If the new cnt == RESET_BITS, assert bus_reset and go to RESET_HOLD.
  - J → if SE0_MIN_BITS ≤ cnt ≤ SE0_MAX_BITS, pulse eop; otherwise pulse line_error. cnt=0, go to LINE.
  - K or SE1 → pulse line_error, cnt=0, go to LINE.
- RESET_HOLD:
  - SE0 → stay; cnt saturates at RESET_BITS; bus_reset stays high.
  - Any non-SE0 → deassert bus_reset, cnt=0, go to LINE. No eop and no line_error; SE1 here is not flagged.
- se0_active is updated on every strobe to (symbol == SE0); it holds between strobes.
- eop and line_error are mutually exclusive and never both high in a cycle.
- shift_enable low: state, cnt, se0_active and bus_reset hold; eop and line_error are 0.
- An SE0 run longer than SE0_MAX_BITS but shorter than RESET_BITS, ended by J, gives line_error.

## Timing
- All outputs are registered. A strobe sampled at rising edge n produces its responses in the cycle after edge n.
- Latency from the terminating J strobe to eop is 1 clk. eop and line_error are exactly 1 clk wide, even if shift_enable stays high for consecutive cycles.
- bus_reset rises 1 clk after the RESET_BITS-th consecutive SE0 strobe. It falls 1 clk after the first non-SE0 strobe.
- Back-to-back strobes on every clk are legal; each is evaluated independently.
- Reset is asynchronous, at any time including mid-SE0 or during RESET_HOLD:
  - State = LINE, cnt = 0.
  - eop = 0, line_error = 0, se0_active = 0, bus_reset = 0.
- First strobe after reset release is evaluated from LINE.

## Test plan
- Defaults apply throughout (MIN=2, MAX=3, RESET=10, full speed).
- Valid EOP: strobes K, SE0, SE0, J → eop=1 for one clk, the clk after the J strobe. se0_active=1 after the 1st SE0 and 0 after J. line_error stays 0.
- Short and long SE0: SE0×1 then J → line_error pulse, no eop. SE0×4 then J → line_error pulse. SE0×3 then J → eop pulse.
- Bad termination: SE0, SE0, K → line_error pulse, no eop, state returns to LINE. Then SE1 in LINE → second line_error pulse.
- Bus reset: 10 consecutive SE0 strobes → bus_reset rises after the 10th. 5 further SE0 strobes → stays high. J → falls 1 clk later, with no eop and no line_error.
- Strobe gating: SE0, SE0 with shift_enable low for 20 clks between them, then J → eop pulse. cnt is unaffected by non-strobe cycles.
- Async reset: assert rst mid-bus_reset (after 12 SE0 strobes) → all outputs 0 immediately. After release: SE0, SE0, J → eop.
